rgb_stream_arbiter: RTL
=======================

Name: rgb_stream_arbiter

Overview:
- Two-input, packet-aware round-robin arbiter that shares one registered RGB pixel output stage between two pixel sources.
- Each source presents an r/g/b pixel beat with a valid/ready handshake and a last flag.
- Once granted, a source keeps the output until its last beat is accepted.
- Sits upstream of the registered RGB composite stages; single clock domain.

Parameters:
- DATA_W, 8, width of each colour channel (r, g, b).
- INIT_PRIO, 0, source given priority out of reset (0 or 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in0_valid  input  1  source 0 beat valid.
- in0_ready  output  1  source 0 beat accepted this cycle when high together with in0_valid.
- in0_last  input  1  source 0 beat is last of packet.
- in0_r / in0_g / in0_b  input  DATA_W each  source 0 pixel channels.
- in1_valid, in1_ready, in1_last, in1_r, in1_g, in1_b  same as source 0, for source 1.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_last  output  1  registered last flag.
- out_src  output  1  source index of the registered beat.
- out_r / out_g / out_b  output  DATA_W each  registered pixel channels.
- gnt_cnt0 / gnt_cnt1  output  16 each  accepted-packet counters (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_last=0, out_src=0, out_r/g/b=0, state=IDLE, prio=INIT_PRIO, counters=0.
  - Reset mid-packet drops the held beat and any lock; no beat is emitted in that cycle.
- can_load = ~out_valid | out_ready.
- State machine has three states: IDLE, LOCK0, LOCK1.
- Grant selection:
  - IDLE with only one valid: grant that source.
  - IDLE with both valid: grant prio.
  - LOCKk: grant k only, even if k is not valid. The other source waits.
- inK_ready = can_load & grant==K. It is combinational from state, valids, prio, out_valid and out_ready. It never depends on the requester's own valid in LOCK states.
- Beat accept: inK_valid & inK_ready. On the next edge:
  - out_r/g/b, out_last load from the source.
  - out_src=K, out_valid=1.
- If can_load is true but no beat is accepted, out_valid goes to 0 next cycle.
- If can_load is false, the output register holds all values.
- Latency: accepted beat appears on out_* exactly 1 cycle later. Throughput is 1 beat/cycle with out_ready held high.
- Transitions:
  - IDLE, accept from K with last=0 -> LOCKK.
  - IDLE, accept from K with last=1 -> stay IDLE; prio=~K (single-beat packet).
  - LOCKK, accept with last=1 -> IDLE; prio=~K.
  - LOCKK, otherwise -> stay LOCKK.
- Round-robin: prio only changes on packet completion (last beat accepted). An idle source never steals prio.
- Simultaneous events in the same cycle:
  - Downstream consume plus new accept: the register is replaced, with no bubble.
  - Packet completion in IDLE: prio flips and the new state is evaluated next cycle. The other source is never granted in the same cycle a packet ends.
- Valid drop during a lock is legal; the lock persists.
- All data/last registers load only on accept. Outputs do not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: RGB_STREAM_ARBITER_STATS_EN.
- Defined: gnt_cnt0/gnt_cnt1 increment by 1 on each accepted last beat from source 0/1.
  - They wrap from 16'hFFFF to 0.
  - They clear on reset.
- Undefined: gnt_cnt0/gnt_cnt1 are tied to 0 and no counter flops exist. Arbitration behaviour is identical in both builds.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, valids 0 -> out_valid=0, out_r/g/b=0, in0_ready=1 (prio 0, output empty), in1_ready=0.
- Single source stream: in0 sends 3 beats r=8'h10,11,12 with last on the third, out_ready=1 -> out_r=10,11,12 on cycles 1-3 after each accept, out_src=0, out_last only on the third; prio becomes 1.
- Contention round-robin: both valid, in0 two-beat packets, in1 one-beat packets, out_ready=1 -> out_src sequence 0,0,1,0,0,1 with no idle cycles between packets other than the IDLE re-arbitration.
- Backpressure: out_ready=0 for 4 cycles mid-packet -> out_* stable, in0_ready=0 throughout; resumes with no lost or duplicated beat (r 8'h21 follows 8'h20).
- Lock hold: source 0 in LOCK0 drops valid for 3 cycles while in1_valid=1 -> in1_ready stays 0; source 0 finishes with last, then source 1 is granted.
- Reset mid-packet plus stats (STATS_EN): reset asserted during LOCK1 -> next cycle IDLE, out_valid=0, prio=0, gnt_cnt0/1=0. With 65536 completed source-0 packets, gnt_cnt0 wraps to 0.

Source files
------------

// File: rtl/rgb_stream_arbiter_if.sv
// Handshake bundle for rgb_stream_arbiter: two pixel sources in, one registered stream out.
// master: the environment (sources and downstream sink). slave: the arbiter.
interface rgb_stream_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              in0_valid;
  logic              in0_ready;
  logic              in0_last;
  logic [DATA_W-1:0] in0_r;
  logic [DATA_W-1:0] in0_g;
  logic [DATA_W-1:0] in0_b;

  logic              in1_valid;
  logic              in1_ready;
  logic              in1_last;
  logic [DATA_W-1:0] in1_r;
  logic [DATA_W-1:0] in1_g;
  logic [DATA_W-1:0] in1_b;

  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              out_src;
  logic [DATA_W-1:0] out_r;
  logic [DATA_W-1:0] out_g;
  logic [DATA_W-1:0] out_b;

  modport master (
    output in0_valid, in0_last, in0_r, in0_g, in0_b,
    input  in0_ready,
    output in1_valid, in1_last, in1_r, in1_g, in1_b,
    input  in1_ready,
    input  out_valid, out_last, out_src, out_r, out_g, out_b,
    output out_ready
  );

  modport slave (
    input  in0_valid, in0_last, in0_r, in0_g, in0_b,
    output in0_ready,
    input  in1_valid, in1_last, in1_r, in1_g, in1_b,
    output in1_ready,
    output out_valid, out_last, out_src, out_r, out_g, out_b,
    input  out_ready
  );
endinterface

// File: rtl/rgb_stream_arbiter.sv
// Packet-aware two-source round-robin arbiter feeding one registered RGB output stage.
// Optional grant statistics counters: define RGB_STREAM_ARBITER_STATS_EN.
//
// state | meaning
// IDLE  | no packet in flight; grant follows valids, prio breaks ties
// LOCK0 | source 0 owns the output until its last beat is accepted
// LOCK1 | source 1 owns the output until its last beat is accepted
module rgb_stream_arbiter #(
  parameter int DATA_W    = 8,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  rgb_stream_arbiter_if.slave   bus,
  output logic [15:0]           gnt_cnt0,
  output logic [15:0]           gnt_cnt1
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic              prio_nxt;
  logic              can_load;
  logic              grant;
  logic              in0_rdy;
  logic              in1_rdy;
  logic              accept;
  logic              acc_last;
  logic [DATA_W-1:0] sel_r;
  logic [DATA_W-1:0] sel_g;
  logic [DATA_W-1:0] sel_b;

  logic              out_valid_q;
  logic              out_last_q;
  logic              out_src_q;
  logic [DATA_W-1:0] out_r_q;
  logic [DATA_W-1:0] out_g_q;
  logic [DATA_W-1:0] out_b_q;

  // State and round-robin priority registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      prio  <= INIT_PRIO;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  // Grant selection, ready generation and next-state decode
  always_comb begin
    can_load  = ~out_valid_q | bus.out_ready;
    grant     = 1'b0;
    state_nxt = state;
    prio_nxt  = prio;
    case (state)
      // A lone requester wins outright; a tie (or no request) goes to prio.
      IDLE:    grant = (bus.in0_valid ^ bus.in1_valid) ? bus.in1_valid : prio;
      LOCK0:   grant = 1'b0;
      LOCK1:   grant = 1'b1;
      default: grant = 1'b0;
    endcase
    in0_rdy  = can_load & ~grant;
    in1_rdy  = can_load & grant;
    accept   = grant ? (bus.in1_valid & in1_rdy) : (bus.in0_valid & in0_rdy);
    acc_last = grant ? bus.in1_last : bus.in0_last;
    sel_r    = grant ? bus.in1_r : bus.in0_r;
    sel_g    = grant ? bus.in1_g : bus.in0_g;
    sel_b    = grant ? bus.in1_b : bus.in0_b;
    if (accept) begin
      if (acc_last) begin
        // Packet done: hand priority to the other source, re-arbitrate next cycle.
        state_nxt = IDLE;
        prio_nxt  = ~grant;
      end else begin
        state_nxt = grant ? LOCK1 : LOCK0;
      end
    end
  end

  // Output register: load on accept, drain to empty when free, hold under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
      out_r_q     <= '0;
      out_g_q     <= '0;
      out_b_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_last_q  <= acc_last;
      out_src_q   <= grant;
      out_r_q     <= sel_r;
      out_g_q     <= sel_g;
      out_b_q     <= sel_b;
    end else if (can_load) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in0_ready = in0_rdy;
  assign bus.in1_ready = in1_rdy;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.out_r     = out_r_q;
  assign bus.out_g     = out_g_q;
  assign bus.out_b     = out_b_q;

`ifdef RGB_STREAM_ARBITER_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  // Completed-packet counters, wrapping at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else if (accept && acc_last) begin
      if (grant) cnt1_q <= cnt1_q + 16'd1;
      else       cnt0_q <= cnt0_q + 16'd1;
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = 16'd0;
  assign gnt_cnt1 = 16'd0;
`endif

endmodule
